// File: rtl/lsu_if.sv
// Request/response handshake and data memory port of the load/store unit.
// master drives requests and models dmem; slave is the lsu itself.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_wmask;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata, resp_ready,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_addr, mem_wdata,
    input  mem_wmask, mem_we
  );

  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_addr, mem_wdata,
    output mem_wmask, mem_we
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one access per request, split into two beats
// when it crosses a word boundary; extends load data on response.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, RESP
  } state_t;

  state_t          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [2:0]      n, n1;
  logic [1:0]      off;
  logic            split;
  logic [XLEN-1:0] sm, n1m;
  logic [4:0]      offs, sh1;
  logic            ill;

  always_comb begin
    n   = 3'd4;
    sm  = {XLEN{1'b1}};
    off = addr_q[1:0];
    unique case (f3_q[1:0])
      2'b00: begin n = 3'd1; sm = 32'h0000_00ff; end
      2'b01: begin n = 3'd2; sm = 32'h0000_ffff; end
      default: ;
    endcase
    split = ({1'b0, off} + n) > 3'd4;
    n1    = split ? 3'd4 - {1'b0, off} : n;
    unique case (n1)
      3'd1:    n1m = 32'h0000_00ff;
      3'd2:    n1m = 32'h0000_ffff;
      3'd3:    n1m = 32'h00ff_ffff;
      default: n1m = {XLEN{1'b1}};
    endcase
    offs = {off, 3'b000};
    sh1  = {n1[1:0], 3'b000};
    ill  = (bus.req_funct3[1:0] == 2'b11)
        || (bus.req_funct3[2] && bus.req_funct3[1])
        || (bus.req_store && bus.req_funct3[2]);
  end

  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    f3_d           = f3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    data_d         = data_q;
    err_d          = err_q;
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wmask  = '0;
    bus.mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          data_d  = '0;
          err_d   = ill;
          state_d = ill ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wmask = sm & n1m;
        bus.mem_we    = store_q;
        if (!store_q)
          data_d = (bus.mem_rdata >> offs) & n1m;
        state_d = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00} + XLEN'(4);
        bus.mem_wdata = wdata_q >> sh1;
        bus.mem_wmask = sm >> sh1;
        bus.mem_we    = store_q;
        if (!store_q)
          data_d = (data_q | (bus.mem_rdata << sh1)) & sm;
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        // data_q is already masked to n bytes, so BU/HU/W pass as-is
        if (!err_q && !store_q) begin
          unique case (f3_q)
            3'b000:  bus.resp_rdata = {{24{data_q[7]}}, data_q[7:0]};
            3'b001:  bus.resp_rdata = {{16{data_q[15]}}, data_q[15:0]};
            default: bus.resp_rdata = data_q;
          endcase
        end
        if (bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: dmem model, vector table with response scoreboard,
// plus split-store, backpressure and mid-access reset sequences.
module tb_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(32)) bus ();

  lsu #(.XLEN(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic [31:0] wm, wd;

  assign wm = bus.mem_wmask << {bus.mem_addr[1:0], 3'b000};
  assign wd = bus.mem_wdata << {bus.mem_addr[1:0], 3'b000};
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_val;
    else if (bus.mem_we)
      mem[bus.mem_addr[5:2]] <= (mem[bus.mem_addr[5:2]] & ~wm) | (wd & wm);
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          beats;
    int          wes;
  } tv_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  tv_t         tv[17];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] b_addr[2];
  logic [31:0] b_mask[2];
  logic [31:0] b_data[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 4'(idx);
    poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic issue(input tv_t v, input string nm);
    int   cyc, beats, wes;
    logic got;
    exp_t g;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = v.st;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sbq.push_back('{v.rd, v.err});
    #1 bus.req_valid = 1'b0;
    cyc = 0; beats = 0; wes = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        if (bus.mem_wmask != 0) begin
          if (beats < 2) begin
            b_addr[beats] = bus.mem_addr;
            b_mask[beats] = bus.mem_wmask;
            b_data[beats] = bus.mem_wdata;
          end
          beats++;
        end
        if (bus.mem_we) wes++;
      end
    end
    chk({nm, "_resp"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(cyc), 32'(v.lat));
    chk({nm, "_beats"}, 32'(beats), 32'(v.beats));
    chk({nm, "_we"}, 32'(wes), 32'(v.wes));
    g = sbq.pop_front();
    if (got) begin
      chk({nm, "_rdata"}, bus.resp_rdata, g.rd);
      chk({nm, "_err"}, 32'(bus.resp_err), 32'(g.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    tv[0]  = '{0, 3'b010, 32'h10, 0, 32'h8765_4321, 0, 2, 1, 0};
    tv[1]  = '{0, 3'b000, 32'h13, 0, 32'hFFFF_FF87, 0, 2, 1, 0};
    tv[2]  = '{0, 3'b100, 32'h13, 0, 32'h0000_0087, 0, 2, 1, 0};
    tv[3]  = '{0, 3'b001, 32'h12, 0, 32'hFFFF_8765, 0, 2, 1, 0};
    tv[4]  = '{0, 3'b101, 32'h12, 0, 32'h0000_8765, 0, 2, 1, 0};
    tv[5]  = '{0, 3'b000, 32'h10, 0, 32'h0000_0021, 0, 2, 1, 0};
    tv[6]  = '{0, 3'b010, 32'h12, 0, 32'h6655_8765, 0, 3, 2, 0};
    tv[7]  = '{0, 3'b001, 32'h17, 0, 32'hFFFF_FF88, 0, 3, 2, 0};
    tv[8]  = '{0, 3'b100, 32'h16, 0, 32'h0000_0077, 0, 2, 1, 0};
    tv[9]  = '{0, 3'b011, 32'h10, 0, 32'h0, 1, 1, 0, 0};
    tv[10] = '{0, 3'b110, 32'h10, 0, 32'h0, 1, 1, 0, 0};
    tv[11] = '{1, 3'b000, 32'h18, 32'h1234_5678, 32'h0, 0, 2, 1, 1};
    tv[12] = '{0, 3'b101, 32'h18, 0, 32'h0000_8078, 0, 2, 1, 0};
    tv[13] = '{0, 3'b001, 32'h18, 0, 32'hFFFF_8078, 0, 2, 1, 0};
    tv[14] = '{1, 3'b010, 32'h1A, 32'hDEAD_BEEF, 32'h0, 0, 3, 2, 2};
    tv[15] = '{0, 3'b010, 32'h1A, 0, 32'hDEAD_BEEF, 0, 3, 2, 0};
    tv[16] = '{1, 3'b101, 32'h10, 32'h55, 32'h0, 1, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_port", bus.mem_addr | bus.mem_wdata | bus.mem_wmask, 32'd0);
    rst_n = 1'b1;

    preset(4, 32'h8765_4321);
    preset(5, 32'h8877_6655);
    preset(6, 32'h0000_80FF);
    preset(7, 32'h0000_0000);
    for (int i = 0; i < 17; i++)
      issue(tv[i], $sformatf("v%0d", i));
    @(negedge clk);
    chk("sw_split_w6", mem[6], 32'hBEEF_8078);
    chk("sw_split_w7", mem[7], 32'h0000_DEAD);

    preset(4, 32'hFFFF_FFFF);
    preset(5, 32'hFFFF_FFFF);
    issue('{1, 3'b001, 32'h13, 32'h0000_ABCD, 32'h0, 0, 3, 2, 2}, "sh");
    chk("sh_b0_addr", b_addr[0], 32'h13);
    chk("sh_b0_mask", b_mask[0], 32'hFF);
    chk("sh_b0_data", b_data[0], 32'hABCD);
    chk("sh_b1_addr", b_addr[1], 32'h14);
    chk("sh_b1_mask", b_mask[1], 32'hFF);
    chk("sh_b1_data", b_data[1], 32'hAB);
    @(negedge clk);
    chk("sh_w10", mem[4], 32'hCDFF_FFFF);
    chk("sh_w14", mem[5], 32'hFFFF_FFAB);

    preset(4, 32'h4433_2211);
    preset(5, 32'h8877_6655);
    issue('{0, 3'b010, 32'h12, 0, 32'h6655_4433, 0, 3, 2, 0}, "lw_split");
    issue('{0, 3'b101, 32'h13, 0, 32'h0000_5544, 0, 3, 2, 0}, "lhu_split");

    // illegal store held under backpressure, new request waiting
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b100;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    @(negedge clk);
    chk("bp_valid_c1", 32'(bus.resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k),
          {bus.resp_valid, bus.resp_err, bus.req_ready, bus.mem_we},
          {1'b1, 1'b1, 1'b0, 1'b0});
      chk($sformatf("bp_rdata%0d", k), bus.resp_rdata, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("same_cyc_idle", {bus.req_ready, bus.resp_valid}, 32'b10);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("same_cyc_valid", 32'(bus.resp_valid), 32'd1);
    chk("same_cyc_rdata", bus.resp_rdata, 32'h4433_2211);
    chk("bp_no_write", mem[4], 32'h4433_2211);

    // reset during beat 1 of a split SW
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h16;
    bus.req_wdata  = 32'h1122_3344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rma_beat1_we", {bus.mem_we, bus.mem_addr}, {1'b1, 32'h18});
    rst_n = 1'b0;
    #1;
    chk("rma_we_async", 32'(bus.mem_we), 32'd0);
    chk("rma_addr", bus.mem_addr, 32'd0);
    chk("rma_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rma_ready", {bus.req_ready, bus.resp_valid}, 32'b10);
    issue('{0, 3'b010, 32'h10, 0, 32'h4433_2211, 0, 2, 1, 0}, "rma_lw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator for the word-organised data memory. It sits between the datapath's memory stage and `dmem`, accepting one RISC-V load or store per request handshake and driving the memory's `addr`/`wdata`/`wmask`/`we`/`rdata` port. It splits accesses that cross a 32-bit word boundary into two memory beats, then extracts, sign- or zero-extends and returns load data. Stores and faults complete through the same response handshake.

## Interface
- `XLEN`, 32 (from `constants.vh`): data and address width; the byte lane logic assumes 32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and faults.
- `resp_err`  out  1  illegal funct3; no memory access was made.
- `mem_addr`  out  XLEN  byte address to `dmem`.
- `mem_wdata`  out  XLEN  unshifted store data to `dmem`.
- `mem_wmask`  out  XLEN  unshifted byte mask to `dmem`.
- `mem_we`  out  1  write enable to `dmem`.
- `mem_rdata`  in  XLEN  combinational read word from `dmem`, addressed by `mem_addr`.

## Operation
- **FSM states:** IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- **Latching:**
  - `req_ready` = (state == IDLE).
  - On accept, latch `req_store`, `req_funct3`, `req_addr` and `req_wdata`.
  - Compute the access size n (1/2/4 bytes), the offset `off = addr[1:0]` and `split = off + n > 4`.
- **Illegal requests:**
  - Illegal funct3: 011, 110 or 111 for either kind; 100 or 101 for a store.
  - An illegal request goes IDLE -> RESP with `resp_err = 1`. `mem_we` is never asserted.
- **Size mask:** `sm` = low n bytes of ones. `n1 = split ? 4-off : n` is the byte count of beat 0.
- **BEAT0:**
  - `mem_addr` = latched addr.
  - `mem_wdata` = wdata.
  - `mem_wmask` = `sm` truncated to the low n1 bytes.
  - `mem_we` = store.
  - For a load, capture `mem_rdata >> 8*off` into the low n1 bytes of the data register.
- **BEAT1** (only if `split`):
  - `mem_addr` = `{addr[XLEN-1:2],2'b00} + 4`, wrapping mod 2^XLEN.
  - `mem_wdata` = `wdata >> 8*n1`.
  - `mem_wmask` = `sm >> 8*n1`.
  - `mem_we` = store.
  - For a load, OR `mem_rdata << 8*n1` into the data register, keeping n bytes.
- **Transitions:**
  - IDLE -> BEAT0 on accept.
  - BEAT0 -> BEAT1 if split, else -> RESP.
  - BEAT1 -> RESP.
  - RESP -> IDLE on `resp_ready`.
- **RESP:**
  - `resp_valid = 1`.
  - `resp_rdata`: B/H are sign-extended from bit 8n-1; BU/HU are zero-extended; W is passed through; stores return 0.
  - `resp_rdata` and `resp_err` stay stable until the handshake completes.
- **Idle memory port:** outside BEAT0/BEAT1, `mem_we = 0` and `mem_addr`, `mem_wdata`, `mem_wmask` are 0.

## Timing
- **Reset values:**
  - State IDLE, so `req_ready = 1`.
  - `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`.
  - `mem_we = 0`, `mem_addr`, `mem_wdata` and `mem_wmask` all 0.
- **Latency**, with the request accepted at edge 0:
  - BEAT0 is cycle 1.
  - Non-split: `resp_valid` rises in cycle 2.
  - Split: BEAT1 is cycle 2 and `resp_valid` rises in cycle 3.
  - Illegal: `resp_valid` rises in cycle 1.
  - Throughput is at best one request per 3 cycles, because a request is accepted only in IDLE.
- **Write timing:** `dmem` writes at the edge ending each beat with `mem_we` high. Beat 1 of a split store therefore lands one cycle after beat 0.
- **Memory port decode:** `mem_*` outputs decode directly from the state register. They are glitch-free across the async reset: asserting `rst_n` drops `mem_we` immediately.
- **Reset mid-operation:** reset during BEAT1 abandons the access. Beat 0 may already be committed, and no response is produced.
- **Response backpressure:** `resp_ready` low holds RESP indefinitely. `req_valid` is ignored until IDLE is re-entered.
- **Same-cycle handshake:** `resp_ready` and a new `req_valid` in the same RESP cycle: the response completes, and the request is accepted in the following IDLE cycle.

## Test plan
- **LW, aligned.** Mem word at 0x10 = 0x8765_4321. LW addr 0x10 -> `resp_rdata` 0x8765_4321, `resp_err` 0, `resp_valid` in cycle 2, exactly one BEAT with `mem_we` 0.
- **LB / LBU, sign vs zero extension.** Same word. LB 0x13 -> 0xFFFF_FF87. LBU 0x13 -> 0x0000_0087. LH 0x12 -> 0xFFFF_8765.
- **SH, split store.** Words 0x10 and 0x14 preset to 0xFFFF_FFFF. SH wdata 0xABCD at 0x13:
  - Beat 0: `mem_addr` 0x13, `mem_wmask` 0xFF, `mem_wdata` 0xABCD.
  - Beat 1: `mem_addr` 0x14, `mem_wmask` 0xFF, `mem_wdata` 0xAB.
  - Final words: 0x10 = 0xCDFF_FFFF, 0x14 = 0xFFFF_FFAB. Response in cycle 3.
- **LW, split load.** Words 0x10 = 0x4433_2211, 0x14 = 0x8877_6655. LW 0x12 -> 0x6655_4433. LHU 0x13 -> 0x0000_5544.
- **Illegal funct3 and backpressure.** Store with funct3 100 -> `resp_err` 1, `mem_we` never high, `resp_valid` in cycle 1. Hold `resp_ready` 0 for 5 cycles -> `resp_valid` and data stable, `req_ready` 0.
- **Reset mid-access.** Drop `rst_n` during BEAT1 of a split SW -> `mem_we` 0 asynchronously, `resp_valid` 0, `req_ready` 1 after release. The next LW completes normally.
